mag_result_display: RTL
=======================

// Module: mag_result_display
// PURPOSE
//  Consumer end of the magnitude-comparator result interface. Captures operands A/B and
//  the eq/gt/lt flags on a load strobe, then drives a time-multiplexed 4-digit 7-segment
//  display. Digit map: dig3 = A (hex), dig2 = relation symbol, dig1 = B (hex), dig0 = status.
//  Sits between the comparator outputs and the board display pins.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles each digit stays active; legal range >= 2
//  BLINK_DIV    8       refresh frames per blink half-period; used only with MAG_DISP_ERR_BLINK_EN
// PORTS
//  clk    in   1  system clock; all state changes on the rising edge
//  rst    in   1  asynchronous, active-high reset
//  load   in   1  capture strobe; samples a_in, b_in, eq, gt, lt on the same edge
//  a_in   in   4  operand A
//  b_in   in   4  operand B
//  eq     in   1  comparator flag, A == B
//  gt     in   1  comparator flag, A > B
//  lt     in   1  comparator flag, A < B
//  ack    out  1  one-cycle pulse on the edge after a capture
//  seg    out  7  [0:6] = segments a..g, active-low (0 = lit)
//  an     out  4  digit enables, active-low, one-hot-low; an[3] drives dig3
//  dp     out  1  decimal point, active-low
// BEHAVIOUR
//  Reset (async, immediate): seg = 7'b1111111, an = 4'b1111, dp = 1, ack = 0, refresh
//   counter = 0, digit index = 0, shadow registers = 0, stale flag = 1.
//  Refresh counter: counts 0 .. REFRESH_DIV-1 and wraps. On wrap the digit index
//   increments 0->1->2->3->0.
//  Outputs are registered: at each edge, seg/an/dp are computed from the digit index and
//   shadow registers as they stood before that edge. After reset releases, the first edge
//   gives an = 4'b1110.
//  Capture: load=1 at edge t writes the shadow registers, clears stale, and sets ack at t.
//   ack drops at t+1. New data appears on seg at edge t+1 when its digit is active.
//   A load on every cycle is legal; the last value captured wins.
//  Flag check: flags are valid only when {eq,gt,lt} is exactly one-hot.
//  dig2 symbol: eq -> 7'b1110110 (=); gt -> 7'b1001110 (b,c,g); lt -> 7'b1111000
//   (e,f,g); invalid flags -> blank 7'b1111111.
//  dig0 status: invalid flags -> 'E' 7'b0110000; otherwise blank.
//  dp: lit (0) only while dig0 is active and stale = 1 (nothing captured since reset).
//   Otherwise dp = 1.
//  Hex font, abcdefg: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//   6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010
//   E=0110000 F=0111000.
//  Simultaneous load and digit wrap: both take effect at the same edge.
//   The next output uses the new index and the new shadow data.
//  Reset mid-scan or mid-load: the async clear wins; no partial capture survives.
// CONFIGURATION
//  MAG_DISP_ERR_BLINK_EN defined: a frame counter advances once per dig3->dig0 wrap. When
//   the captured flags are invalid, an is forced to 4'b1111 for alternating BLINK_DIV-frame
//   half-periods, starting with the visible phase after capture. Valid flags never blink.
//  MAG_DISP_ERR_BLINK_EN undefined: no frame counter; invalid flags display steadily.
// TESTING (REFRESH_DIV=4, BLINK_DIV=2)
//  1. Reset held 3 cycles, then released -> seg=7'h7F, an=4'hF, dp=1 during reset.
//     First edge after release: an=4'b1110, dp=0.
//  2. load with A=1, B=2, lt=1 -> ack high 1 cycle. Scanning gives dig3 seg=1001111,
//     dig2 seg=1111000, dig1 seg=0010010, dig0 blank. dp stays 1 from then on.
//  3. load with A=8, B=5, gt=1, coinciding with a digit wrap -> the next output already
//     shows new data: dig3=0000000, dig1=0100100, dig2=1001110.
//  4. load with A=3, B=3, eq=gt=1 -> dig2 blank, dig0=0110000. With the macro defined,
//     an reads 4'hF for 2 of every 4 frames.
//  5. Assert rst mid-scan with an=4'b1011 -> outputs clear in the same cycle with no clock
//     edge. After release, the display shows stale state: dp lit on dig0, operands 0.
//  6. An-walk check over 16 cycles -> an sequence 1110,1101,1011,0111, each held
//     exactly 4 cycles, never two digits low at once.

Source files
------------

// File: rtl/mag_result_display.sv
// Result display: captures A/B and the comparator flags, then scans them onto a 4-digit 7-segment display.
// Latency: ack and the display data follow one edge after load; seg/an/dp are registered (one edge behind the scan state).
// Backpressure: none; a load is accepted on any cycle and the last capture wins. Build option MAG_DISP_ERR_BLINK_EN blinks invalid-flag results.
module mag_result_display #(
    parameter int REFRESH_DIV = 100000,  // clk cycles per digit, >= 2
    parameter int BLINK_DIV   = 8        // frames per blink half-period
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       eq,
    input  logic       gt,
    input  logic       lt,
    output logic       ack,
    output logic [6:0] seg,   // bit 6 = segment a ... bit 0 = segment g, active-low
    output logic [3:0] an,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_EQ    = 7'b1110110;
    localparam logic [6:0] SEG_GT    = 7'b1001110;
    localparam logic [6:0] SEG_LT    = 7'b1111000;
    localparam logic [6:0] SEG_ERR   = 7'b0110000;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    a_q, a_d, b_q, b_d;
    logic [2:0]    flags_q, flags_d;  // {eq, gt, lt}
    logic          stale_q, stale_d;
    logic          ack_q, ack_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          wrap;
    logic          flags_ok;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

`ifdef MAG_DISP_ERR_BLINK_EN
    localparam int FW = $clog2(2 * BLINK_DIV);
    logic [FW-1:0] frame_q, frame_d;
    logic          blank_phase;

    // Frame counter: restarts in the visible phase on capture, advances on each dig3->dig0 wrap.
    always_comb begin
        frame_d = frame_q;
        if (load) begin
            frame_d = '0;
        end else if (wrap && dig_q == 2'd3) begin
            frame_d = (frame_q == FW'(2 * BLINK_DIV - 1)) ? '0 : frame_q + 1'b1;
        end
    end

    assign blank_phase = !flags_ok && (frame_q >= FW'(BLINK_DIV));

    // Frame counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_q <= '0;
        else     frame_q <= frame_d;
    end
`endif

    assign wrap     = (cnt_q == CW'(REFRESH_DIV - 1));
    assign flags_ok = (flags_q == 3'b100) || (flags_q == 3'b010) || (flags_q == 3'b001);

    // Next state: scan counters, shadow capture, and the display word for the current digit.
    always_comb begin
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        dig_d   = wrap ? dig_q + 2'd1 : dig_q;
        a_d     = load ? a_in : a_q;
        b_d     = load ? b_in : b_q;
        flags_d = load ? {eq, gt, lt} : flags_q;
        stale_d = load ? 1'b0 : stale_q;
        ack_d   = load;

        seg_d = SEG_BLANK;
        case (dig_q)
            2'd0: seg_d = flags_ok ? SEG_BLANK : SEG_ERR;
            2'd1: seg_d = hex7(b_q);
            2'd2: begin
                case (flags_q)
                    3'b100:  seg_d = SEG_EQ;
                    3'b010:  seg_d = SEG_GT;
                    3'b001:  seg_d = SEG_LT;
                    default: seg_d = SEG_BLANK;
                endcase
            end
            default: seg_d = hex7(a_q);
        endcase

        an_d = ~(4'b0001 << dig_q);
`ifdef MAG_DISP_ERR_BLINK_EN
        if (blank_phase) an_d = 4'b1111;
`endif
        dp_d = !((dig_q == 2'd0) && stale_q);
    end

    // State and output registers; reset blanks the display and marks the shadow data stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            flags_q <= 3'd0;
            stale_q <= 1'b1;
            ack_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            stale_q <= stale_d;
            ack_q   <= ack_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign ack = ack_q;
    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
